// File: rtl/core_sram_responder_if.sv
// Core bus (req/gnt/rvalid) bundle between an Ibex-style master and a memory slave.
interface core_sram_responder_if;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/core_sram_responder.sv
// Single-port SRAM responder for the core req/gnt/rvalid bus.
// One grant per transaction, response one cycle after the grant, optional
// wait states before each grant.
// Optional feature: define CORE_SRAM_BOUNDS_CHECK_EN to answer out-of-range
// addresses with err=1 and suppress their writes; otherwise addresses alias.
module core_sram_responder #(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  core_sram_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        rvalid_reg;
  logic        resp_read_reg;
  logic [31:0] rd_word_reg;
  logic [31:0] mem [DEPTH];

  logic [32:0]   diff;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          grant;
  logic          mem_we;
  logic          mem_re;

  // A 33-bit subtraction exposes a borrow for addresses below the base.
  assign diff   = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
  assign offset = diff[31:0];
  assign idx    = offset[AW+1:2];

`ifdef CORE_SRAM_BOUNDS_CHECK_EN
  logic err_reg;
  assign in_range = !diff[32] && ({1'b0, offset} < (33'(DEPTH) << 2));
  assign bus.err  = err_reg;
`else
  logic unused_addr_bits;
  // Without the range check the upper offset bits simply alias.
  assign unused_addr_bits = ^{diff[32], offset[31:AW+2], offset[1:0]};
  assign in_range = 1'b1;
  assign bus.err  = 1'b0;
`endif

  // Grant is combinational from req; reset always masks it so nothing commits.
  assign grant = !rst && bus.req &&
                 ((WAIT_STATES == 0) ? (state_reg == IDLE)
                                     : (state_reg == WAIT && cnt_reg == 4'd0));

  assign mem_we = grant && bus.we && in_range;
  assign mem_re = grant && !bus.we && in_range;

  assign bus.gnt    = grant;
  assign bus.rvalid = rvalid_reg;
  // Write and error responses return zero data; reads return the registered word.
  assign bus.rdata  = resp_read_reg ? rd_word_reg : 32'h0;

  // Memory array: byte-masked write and registered read, no reset on contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.be[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
    if (mem_re) rd_word_reg <= mem[idx];
  end

  // Wait-state FSM and the single response pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      rvalid_reg    <= 1'b0;
      resp_read_reg <= 1'b0;
`ifdef CORE_SRAM_BOUNDS_CHECK_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      rvalid_reg <= grant;
      if (grant) begin
        resp_read_reg <= mem_re;
`ifdef CORE_SRAM_BOUNDS_CHECK_EN
        err_reg       <= !in_range;
`endif
      end
      case (state_reg)
        IDLE: begin
          if (bus.req && WAIT_STATES != 0) begin
            state_reg <= WAIT;
            cnt_reg   <= 4'(WAIT_STATES - 1);
          end
        end
        WAIT: begin
          if (!bus.req) begin
            // Master withdrew its request: drop it silently.
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
          end else if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_sram_responder.sv
// Self-checking bench for core_sram_responder: a zero-wait instance driven
// from a vector table with a response scoreboard, and a three-wait-state
// instance driven by hand-written timing sequences.
module tb_core_sram_responder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  core_sram_responder_if b0 ();
  core_sram_responder_if b3 ();

  core_sram_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  core_sram_responder #(.DEPTH(4096), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  vec_t  tbl[$];
  resp_t sb[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err);
    vec_t v;
    v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // Response monitor for the zero-wait instance: pop one expectation per rvalid.
  always @(negedge clk) begin
    if (!rst && b0.rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got rvalid=1 want no response");
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("resp_rdata", b0.rdata, e.rdata);
        chk("resp_err", 32'(b0.err), 32'(e.err));
        $display("resp rdata=%h err=%0b", b0.rdata, b0.err);
      end
    end
  end

  // Drive one zero-wait transaction; grant must come in the same cycle.
  task automatic step0(input vec_t v);
    resp_t r;
    b0.req = 1'b1; b0.we = v.we; b0.be = v.be; b0.addr = v.addr; b0.wdata = v.wdata;
    @(negedge clk);
    chk("ws0_gnt", 32'(b0.gnt), 32'd1);
    r.rdata = v.exp_rdata;
    r.err   = v.exp_err;
    sb.push_back(r);
    $display("xact we=%0b be=%h addr=%h wdata=%h exp=%h/%0b",
             v.we, v.be, v.addr, v.wdata, v.exp_rdata, v.exp_err);
    @(posedge clk); #1;
  endtask

  // One request on the three-wait-state instance: gnt at cycle 3, rvalid at 4.
  task automatic run3(input logic we_i, input logic [31:0] addr_i, input logic [31:0] wdata_i,
                      input logic [31:0] exp_rdata);
    b3.req = 1'b1; b3.we = we_i; b3.be = 4'hF; b3.addr = addr_i; b3.wdata = wdata_i;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("ws3_gnt_c%0d", c), 32'(b3.gnt), 32'(c == 3));
      chk($sformatf("ws3_rvalid_c%0d", c), 32'(b3.rvalid), 32'(c == 4));
      if (c == 4) begin
        chk("ws3_rdata", b3.rdata, exp_rdata);
        chk("ws3_err", 32'(b3.err), 32'd0);
      end
      @(posedge clk); #1;
      if (c == 3) b3.req = 1'b0;
    end
    $display("ws3 xact we=%0b addr=%h exp=%h", we_i, addr_i, exp_rdata);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    b0.req = 1'b1; b0.we = 1'b1; b0.be = 4'hF; b0.addr = 32'h0; b0.wdata = 32'hFFFF_FFFF;
    b3.req = 1'b1; b3.we = 1'b1; b3.be = 4'hF; b3.addr = 32'h0; b3.wdata = 32'hFFFF_FFFF;

    // Reset held with req high: everything quiet.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_gnt0", 32'(b0.gnt), 32'd0);
      chk("rst_rvalid0", 32'(b0.rvalid), 32'd0);
      chk("rst_rdata0", b0.rdata, 32'd0);
      chk("rst_err0", 32'(b0.err), 32'd0);
      chk("rst_gnt3", 32'(b3.gnt), 32'd0);
      chk("rst_rvalid3", 32'(b3.rvalid), 32'd0);
      $display("reset cycle %0d", c);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    b0.req = 1'b0;
    b3.req = 1'b0;
    @(posedge clk); #1;

    // Vector table for the zero-wait instance.
    tbl.push_back(mk(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, 32'h20, 32'h1122_3344, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, 4'hF, 32'h20, 32'h0, 32'h11BB_33DD, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, 32'h24, 32'hCAFE_F00D, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 4'h0, 32'h24, 32'hFFFF_FFFF, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, 4'hF, 32'h24, 32'h0, 32'hCAFE_F00D, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, 32'h30, 32'h0000_1234, 32'h0, 1'b0));
    // Eight back-to-back writes, then eight back-to-back reads, of 0x0..0x1C.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b1, 4'hF, 32'(4 * i), 32'h1000_0000 + 32'(i * 32'h111), 32'h0, 1'b0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b0, 4'hF, 32'(4 * i), 32'h0, 32'h1000_0000 + 32'(i * 32'h111), 1'b0));
    // Out-of-range write (DEPTH=1024 words -> 0x1000 is one past the end).
    tbl.push_back(mk(1'b1, 4'hF, 32'h0, 32'hA5A5_A5A5, 32'h0, 1'b0));
`ifdef CORE_SRAM_BOUNDS_CHECK_EN
    tbl.push_back(mk(1'b1, 4'hF, 32'h1000, 32'h5, 32'h0, 1'b1));
    tbl.push_back(mk(1'b0, 4'hF, 32'h0, 32'h0, 32'hA5A5_A5A5, 1'b0));
    tbl.push_back(mk(1'b0, 4'hF, 32'h1000, 32'h0, 32'h0, 1'b1));
`else
    tbl.push_back(mk(1'b1, 4'hF, 32'h1000, 32'h5, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, 4'hF, 32'h0, 32'h0, 32'h5, 1'b0));
`endif

    foreach (tbl[i]) step0(tbl[i]);
    b0.req = 1'b0;
    @(negedge clk);
    chk("ws0_idle_gnt", 32'(b0.gnt), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ws0_idle_rvalid", 32'(b0.rvalid), 32'd0);
    chk("ws0_sb_drained", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Write requested in the same cycle reset rises: no grant, no commit.
    rst = 1'b1;
    b0.req = 1'b1; b0.we = 1'b1; b0.be = 4'hF; b0.addr = 32'h30; b0.wdata = 32'h0000_9999;
    @(negedge clk);
    chk("rstw_gnt", 32'(b0.gnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    b0.req = 1'b0;
    @(negedge clk);
    chk("rstw_rvalid", 32'(b0.rvalid), 32'd0);
    $display("write under reset dropped");
    @(posedge clk); #1;
    step0(mk(1'b0, 4'hF, 32'h30, 32'h0, 32'h0000_1234, 1'b0));
    b0.req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Three wait states: held request, then an abandoned one, then a full-wait read.
    run3(1'b1, 32'h40, 32'h0000_0077, 32'h0);
    b3.req = 1'b1; b3.we = 1'b1; b3.be = 4'hF; b3.addr = 32'h44; b3.wdata = 32'h0000_0BAD;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("abort_gnt_c%0d", c), 32'(b3.gnt), 32'd0);
      chk($sformatf("abort_rvalid_c%0d", c), 32'(b3.rvalid), 32'd0);
      @(posedge clk); #1;
      if (c == 0) b3.req = 1'b0;
    end
    $display("ws3 abandoned request ignored");
    run3(1'b0, 32'h40, 32'h0, 32'h0000_0077);

    chk("final_sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
